// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, line-level bit values and
// the half-bit counter load used to land the start-bit sample mid-bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Half a bit period minus one, floored, never below zero.
  function automatic logic [31:0] half_load(input int p);
    return (p / 2 >= 1) ? 32'(p / 2 - 1) : 32'd0;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-bit 2-flop synchronizer for asynchronous inputs; flops reset to
// RST_VAL so an idle-high line reads as idle straight out of reset.
module synchronizer #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [1:0][WIDTH-1:0] sync_pipe;

  // Two-stage shift toward the output; stage 0 may go metastable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= {2{RST_VAL}};
    else          sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];

endmodule

// File: rtl/uart_receive.sv
// UART receiver: 8N1, LSB first, bit period BAUD_DIVIDE+1 clocks. Start is
// qualified at mid-bit, data/stop are sampled at mid-bit thereafter.
module uart_receive
  import uart_pkg::*;
#(
  parameter int BAUD_DIVIDE = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_char,
  output logic       rx_char_valid,
  output logic       frame_error,
  output logic       rx_active
);

  localparam int          P         = BAUD_DIVIDE + 1;
  localparam logic [31:0] BIT_LOAD  = 32'(P - 1);
  localparam logic [31:0] HALF_LOAD = half_load(P);

  rx_state_t   state, state_nxt;
  logic        rx_s;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        cnt_zero;

  synchronizer #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (uart_rx),
    .q       (rx_s)
  );

  assign cnt_zero  = (cnt == 32'd0);
  assign rx_active = (state != IDLE);

  // Next-state decode; all sampling decisions happen when cnt hits zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (rx_s == START_BIT) state_nxt = START;
      START:      if (cnt_zero) state_nxt = (rx_s == START_BIT) ? DATA : IDLE;
      DATA:       if (cnt_zero && bit_idx == 3'd7) state_nxt = STOP;
      STOP:       if (cnt_zero) state_nxt = (rx_s == STOP_BIT) ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (rx_s == STOP_BIT) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Receiver core: state, bit timer, shift register and output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= 32'd0;
      bit_idx       <= 3'd0;
      shreg         <= 8'h00;
      rx_char       <= 8'h00;
      rx_char_valid <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_nxt;
      rx_char_valid <= 1'b0;
      frame_error   <= 1'b0;
      case (state)
        IDLE: if (rx_s == START_BIT) cnt <= HALF_LOAD;
        START: begin
          if (cnt_zero) begin
            cnt     <= BIT_LOAD;
            bit_idx <= 3'd0;
          end else cnt <= cnt - 32'd1;
        end
        DATA: begin
          if (cnt_zero) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            cnt     <= BIT_LOAD;
          end else cnt <= cnt - 32'd1;
        end
        STOP: begin
          if (cnt_zero) begin
            if (rx_s == STOP_BIT) begin
              rx_char       <= shreg;
              rx_char_valid <= 1'b1;
            end else frame_error <= 1'b1;
          end else cnt <= cnt - 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive at BAUD_DIVIDE=7 (8 clocks/bit).
// A behavioural transmitter drives frames and pushes the expected event
// (character, or -1 for a framing error) into a queue; a monitor pops
// and compares on every output pulse.
module tb_uart_receive;

  localparam int BAUD_DIVIDE = 7;
  localparam int P           = BAUD_DIVIDE + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rx;
  logic [7:0] rx_char;
  logic       rx_char_valid;
  logic       frame_error;
  logic       rx_active;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   n_ferr = 0;
  int   exp_ferr = 0;
  int   last_vcyc = 0;
  int   prev_vcyc = 0;
  int   exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_receive #(.BAUD_DIVIDE(BAUD_DIVIDE)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .uart_rx       (uart_rx),
    .rx_char       (rx_char),
    .rx_char_valid (rx_char_valid),
    .frame_error   (frame_error),
    .rx_active     (rx_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Always resume 1ns after a rising edge so inputs never race the flops.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    wait_cyc(P);
  endtask

  task automatic send_char(input logic [7:0] c, input logic stop);
    if (stop) exp_q.push_back(int'(c));
    else begin
      exp_q.push_back(-1);
      exp_ferr++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(c[i]);
    drive_bit(stop);
  endtask

  // Output monitor against the expected-event queue.
  always @(negedge clk) begin
    int e;
    if (reset_n && (rx_char_valid || frame_error)) begin
      chk("pulse_excl", 32'(rx_char_valid & frame_error), 32'd0);
      chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (rx_char_valid) begin
          chk("rx_char", 32'(rx_char), 32'(e));
          n_valid++;
          prev_vcyc = last_vcyc;
          last_vcyc = cyc;
          if (e >= 0) last_good = 8'(e);
        end else begin
          chk("ferr_expected", 32'(e), 32'hFFFF_FFFF);
          chk("ferr_rx_char_hold", 32'(rx_char), 32'(last_good));
          n_ferr++;
        end
      end
    end
  end

  initial begin
    int nv0, nf0, gap, hold;
    logic [7:0] c;
    logic       stop;

    // Reset values
    reset_n = 1'b0;
    uart_rx = 1'b1;
    wait_cyc(3);
    chk("rst_rx_char", 32'(rx_char), 32'h00);
    chk("rst_valid", 32'(rx_char_valid), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    chk("rst_active", 32'(rx_active), 32'd0);
    reset_n = 1'b1;
    wait_cyc(4);

    // Single 0x55
    nv0 = n_valid; nf0 = n_ferr;
    send_char(8'h55, 1'b1);
    wait_cyc(2 * P);
    chk("n_valid_55", 32'(n_valid - nv0), 32'd1);
    chk("n_ferr_55", 32'(n_ferr - nf0), 32'd0);
    chk("rx_char_55_hold", 32'(rx_char), 32'h55);

    // Back-to-back 0xA5, 0x3C with zero idle
    nv0 = n_valid;
    send_char(8'hA5, 1'b1);
    send_char(8'h3C, 1'b1);
    wait_cyc(2 * P);
    chk("n_valid_b2b", 32'(n_valid - nv0), 32'd2);
    chk("b2b_spacing", 32'(last_vcyc - prev_vcyc), 32'd80);

    // Start glitch: 3 cycles low
    nv0 = n_valid; nf0 = n_ferr;
    uart_rx = 1'b0;
    wait_cyc(3);
    uart_rx = 1'b1;
    chk("glitch_active", 32'(rx_active), 32'd1);
    wait_cyc(6);
    chk("glitch_idle", 32'(rx_active), 32'd0);
    wait_cyc(2 * P);
    chk("glitch_no_valid", 32'(n_valid - nv0), 32'd0);
    chk("glitch_no_ferr", 32'(n_ferr - nf0), 32'd0);

    // Framing error then recovery
    nv0 = n_valid; nf0 = n_ferr;
    send_char(8'h12, 1'b0);
    uart_rx = 1'b0;
    wait_cyc(40);
    chk("break_active", 32'(rx_active), 32'd1);
    uart_rx = 1'b1;
    wait_cyc(P);
    send_char(8'h34, 1'b1);
    wait_cyc(2 * P);
    chk("fe_n_ferr", 32'(n_ferr - nf0), 32'd1);
    chk("fe_n_valid", 32'(n_valid - nv0), 32'd1);
    chk("fe_rx_char", 32'(rx_char), 32'h34);

    // Reset during data bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    uart_rx = 1'b1;
    wait_cyc(4);
    chk("midrst_active_pre", 32'(rx_active), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rx_char", 32'(rx_char), 32'h00);
    chk("midrst_valid", 32'(rx_char_valid), 32'd0);
    chk("midrst_ferr", 32'(frame_error), 32'd0);
    chk("midrst_active", 32'(rx_active), 32'd0);
    last_good = 8'h00;
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_cyc(P);
    nv0 = n_valid;
    send_char(8'h81, 1'b1);
    wait_cyc(2 * P);
    chk("midrst_n_valid", 32'(n_valid - nv0), 32'd1);
    chk("midrst_next_char", 32'(rx_char), 32'h81);

    // Loopback sweep 0x00..0xFF with random short gaps
    nv0 = n_valid; nf0 = n_ferr;
    for (int i = 0; i < 256; i++) begin
      send_char(8'(i), 1'b1);
      if ($urandom_range(0, 3) != 0) begin
        gap = $urandom_range(0, 5);
        if (gap != 0) wait_cyc(gap);
      end
    end
    wait_cyc(2 * P);
    chk("sweep_n_valid", 32'(n_valid - nv0), 32'd256);
    chk("sweep_n_ferr", 32'(n_ferr - nf0), 32'd0);

    // Random mix: characters, framing errors, short glitches
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        uart_rx = 1'b0;
        wait_cyc($urandom_range(1, 3));
        uart_rx = 1'b1;
        wait_cyc(P);
      end
      c    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 6) != 0);
      send_char(c, stop);
      if (!stop) begin
        hold = $urandom_range(0, 20);
        uart_rx = 1'b0;
        if (hold != 0) wait_cyc(hold);
        uart_rx = 1'b1;
        wait_cyc(P);
      end
      gap = $urandom_range(0, 10);
      if (gap != 0) wait_cyc(gap);
    end
    wait_cyc(3 * P);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    chk("final_n_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("final_idle", 32'(rx_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
